axis_pkt_checker_64: RTL and testbench

//  AXI4-Stream sink/checker, the receiving end of the ADC data-producer stream format.

---
 rtl/axis_pkt_checker_64.sv | 118 +++++++++++
 tb/tb_axis_pkt_checker_64.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_checker_64.sv
// axis_pkt_checker_64: AXI4-Stream sink that checks ADC word pattern and packet framing
// Ports:
//   user_clk, user_rstn        clock, asynchronous active-low reset
//   dma_ena                    enables reception; low forces IDLE
//   throttle[3:0]              idle cycles inserted after each accepted beat
//   err_clr                    synchronous clear of counters and sticky flags
//   s_axis_t{data,keep,valid,last}, s_axis_tready   AXI4-Stream sink
//   pkt_ok_count[31:0]         error-free packets (wrapping)
//   err_count[15:0]            erroneous beats (saturating)
//   data_err, frame_err        sticky error flags
//   state_o[1:0]               00 IDLE, 01 RUN, 10 RESYNC
module axis_pkt_checker_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int PKT_WORDS = 2048,
  parameter int IDX_WIDTH = 28,
  parameter logic [DATA_WIDTH-IDX_WIDTH-1:0] MAGIC = 36'h0_000A_0000
) (
  input  logic                  user_clk,
  input  logic                  user_rstn,
  input  logic                  dma_ena,
  input  logic [3:0]            throttle,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [31:0]           pkt_ok_count,
  output logic [15:0]           err_count,
  output logic                  data_err,
  output logic                  frame_err,
  output logic [1:0]            state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, RESYNC = 2'b10} state_t;
  state_t               r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_idx, w_idx_nxt;
  logic                 r_pkt_bad, w_pkt_bad_nxt;
  logic [3:0]           r_hold;
  logic [31:0]          r_pkt_ok;
  logic [15:0]          r_err_count;
  logic                 r_data_err, r_frame_err;
  logic                 w_beat, w_run_beat, w_resync_beat, w_last_idx;
  logic                 w_data_fail, w_frame_fail, w_good_end;
  assign s_axis_tready = (r_state != IDLE) && (r_hold == 4'd0);
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  // a beat coinciding with dma_ena falling belongs to an abandoned packet
  assign w_run_beat    = w_beat && dma_ena && (r_state == RUN);
  assign w_resync_beat = w_beat && dma_ena && (r_state == RESYNC);
  assign w_last_idx    = r_idx == IDX_WIDTH'(PKT_WORDS - 1);
  assign w_data_fail   = w_run_beat && ((s_axis_tdata[DATA_WIDTH-1:IDX_WIDTH] != MAGIC) ||
                         (s_axis_tdata[IDX_WIDTH-1:0] != r_idx) ||
                         (s_axis_tkeep != {KEEP_WIDTH{1'b1}}));
  assign w_frame_fail  = w_run_beat && (s_axis_tlast != w_last_idx);
  assign w_good_end    = w_run_beat && s_axis_tlast && w_last_idx && !r_pkt_bad && !w_data_fail;
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pkt_bad_nxt = r_pkt_bad;
    if (!dma_ena) begin
      w_state_nxt = IDLE;
    end else if (r_state == IDLE) begin
      w_state_nxt   = RUN;
      w_idx_nxt     = '0;
      w_pkt_bad_nxt = 1'b0;
    end else if (w_run_beat) begin
      if (s_axis_tlast) begin
        w_idx_nxt     = '0;
        w_pkt_bad_nxt = 1'b0;
      end else if (w_last_idx) begin
        w_state_nxt = RESYNC;
      end else begin
        w_idx_nxt     = r_idx + IDX_WIDTH'(1);
        w_pkt_bad_nxt = r_pkt_bad || w_data_fail;
      end
    end else if (w_resync_beat && s_axis_tlast) begin
      w_state_nxt   = RUN;
      w_idx_nxt     = '0;
      w_pkt_bad_nxt = 1'b0;
    end
  end
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pkt_bad <= 1'b0;
      r_hold    <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pkt_bad <= w_pkt_bad_nxt;
      r_hold    <= w_beat ? throttle : (r_hold != 4'd0) ? r_hold - 4'd1 : r_hold;
    end
  end
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_pkt_ok    <= '0;
      r_err_count <= '0;
      r_data_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (err_clr) begin
      r_pkt_ok    <= '0;
      r_err_count <= '0;
      r_data_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_good_end) r_pkt_ok <= r_pkt_ok + 32'd1;
      if ((w_data_fail || w_frame_fail) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      if (w_data_fail) r_data_err <= 1'b1;
      if (w_frame_fail) r_frame_err <= 1'b1;
    end
  end
  assign pkt_ok_count = r_pkt_ok;
  assign err_count    = r_err_count;
  assign data_err     = r_data_err;
  assign frame_err    = r_frame_err;
  assign state_o      = r_state;
endmodule

// File: tb/tb_axis_pkt_checker_64.sv
// tb_axis_pkt_checker_64: directed bench with an expected-status scoreboard
module tb_axis_pkt_checker_64;
  localparam logic [35:0] MAGIC = 36'h0_000A_0000;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_RESYNC = 2'b10;
  logic        user_clk = 1'b0;
  logic        user_rstn, dma_ena, err_clr;
  logic [3:0]  throttle;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] pkt_ok_count;
  logic [15:0] err_count;
  logic        data_err, frame_err;
  logic [1:0]  state_o;
  logic [51:0] w_status;
  int n_chk = 0;
  int n_pass = 0;
  int stalls;
  typedef struct {string tag; logic [51:0] st;} exp_t;
  exp_t sb[$];
  always #5 user_clk = ~user_clk;
  assign w_status = {pkt_ok_count, err_count, data_err, frame_err, state_o};
  axis_pkt_checker_64 dut (
    .user_clk(user_clk), .user_rstn(user_rstn), .dma_ena(dma_ena), .throttle(throttle),
    .err_clr(err_clr), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .pkt_ok_count(pkt_ok_count), .err_count(err_count), .data_err(data_err),
    .frame_err(frame_err), .state_o(state_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask
  task automatic expect_st(input string tag, input logic [31:0] ok, input logic [15:0] err,
                           input logic de, input logic fe, input logic [1:0] st);
    sb.push_back('{tag, {ok, err, de, fe, st}});
  endtask
  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, 64'(w_status), 64'(e.st));
    end
  endtask
  // kind: 1 = idx field off by one, 2 = partial tkeep, 3 = wrong magic (applied on beat bad_at)
  task automatic send_pkt(input int n, input int last_at, input int bad_at, input int kind,
                          output int stalled);
    stalled = 0;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      logic [27:0] ix = 28'(i);
      if (i == bad_at && kind == 1) ix = ix + 28'd1;
      s_axis_tdata  = {MAGIC, ix};
      s_axis_tkeep  = (i == bad_at && kind == 2) ? 8'h7F : 8'hFF;
      if (i == bad_at && kind == 3) s_axis_tdata[63] = 1'b1;
      s_axis_tlast  = (i == last_at);
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && w < 64) begin
        @(negedge user_clk);
        w++;
      end
      if (w >= 64) chk("ready_timeout", 64'(w), 64'd0);
      stalled += w;
      @(negedge user_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge user_clk);
    err_clr = 1'b0;
  endtask
  initial begin
    user_rstn = 1'b0; dma_ena = 1'b0; err_clr = 1'b0; throttle = 4'd0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge user_clk);
    expect_st("reset_status", 0, 0, 0, 0, S_IDLE);
    check_sb();
    chk("reset_tready", 64'(s_axis_tready), 64'd0);
    user_rstn = 1'b1;
    dma_ena = 1'b1;
    @(negedge user_clk);
    expect_st("enable_run", 0, 0, 0, 0, S_RUN);
    check_sb();
    chk("run_tready", 64'(s_axis_tready), 64'd1);
    // three clean packets at full rate
    expect_st("clean_x3", 3, 0, 0, 0, S_RUN);
    for (int p = 0; p < 3; p++) begin
      int s;
      send_pkt(2048, 2047, -1, 0, s);
      stalls += s;
    end
    check_sb();
    chk("full_rate_stalls", 64'(stalls), 64'd0);
    // throttle 3: ready drops for exactly 3 cycles after every beat
    throttle = 4'd3;
    expect_st("throttled_pkt", 4, 0, 0, 0, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    chk("throttle_stalls", 64'(stalls), 64'(3 * 2047));
    chk("tready_after_beat", 64'(s_axis_tready), 64'd0);
    throttle = 4'd0;
    // corrupted index on beat 100
    pulse_clr();
    expect_st("clr_zero", 0, 0, 0, 0, S_RUN);
    check_sb();
    expect_st("bad_idx_pkt", 0, 1, 1, 0, S_RUN);
    send_pkt(2048, 2047, 100, 1, stalls);
    check_sb();
    expect_st("after_bad_idx_clean", 1, 1, 1, 0, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    // early tlast on beat 10
    pulse_clr();
    expect_st("early_tlast", 0, 1, 0, 1, S_RUN);
    send_pkt(11, 10, -1, 0, stalls);
    check_sb();
    expect_st("after_early_clean", 1, 1, 0, 1, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    // missing tlast -> RESYNC, discard 5 beats, then recover
    pulse_clr();
    expect_st("missing_tlast", 0, 1, 0, 1, S_RESYNC);
    send_pkt(2048, -1, -1, 0, stalls);
    check_sb();
    expect_st("resync_discard", 0, 1, 0, 1, S_RESYNC);
    send_pkt(4, -1, 0, 3, stalls);
    check_sb();
    expect_st("resync_exit", 0, 1, 0, 1, S_RUN);
    send_pkt(1, 0, 0, 2, stalls);
    check_sb();
    expect_st("after_resync_clean", 1, 1, 0, 1, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    // err_count saturation from a preloaded value
    pulse_clr();
    force dut.r_err_count = 16'hFFFD;
    @(negedge user_clk);
    release dut.r_err_count;
    chk("preload_err", 64'(err_count), 64'hFFFD);
    expect_st("sat_fffe", 0, 16'hFFFE, 0, 1, S_RUN);
    send_pkt(1, 0, -1, 0, stalls);
    check_sb();
    expect_st("sat_ffff", 0, 16'hFFFF, 0, 1, S_RUN);
    send_pkt(1, 0, -1, 0, stalls);
    check_sb();
    expect_st("sat_hold", 0, 16'hFFFF, 1, 1, S_RUN);
    send_pkt(1, 0, 0, 1, stalls);
    check_sb();
    // clear wins over a coincident error beat
    err_clr = 1'b1;
    expect_st("clr_wins", 0, 0, 0, 0, S_RUN);
    send_pkt(1, 0, 0, 1, stalls);
    err_clr = 1'b0;
    check_sb();
    // dma_ena drop mid-packet
    expect_st("partial_pkt", 0, 0, 0, 0, S_RUN);
    send_pkt(5, -1, -1, 0, stalls);
    check_sb();
    dma_ena = 1'b0;
    @(negedge user_clk);
    expect_st("dma_off_idle", 0, 0, 0, 0, S_IDLE);
    check_sb();
    chk("dma_off_tready", 64'(s_axis_tready), 64'd0);
    dma_ena = 1'b1;
    @(negedge user_clk);
    expect_st("reenable_clean", 1, 0, 0, 0, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    // asynchronous reset mid-packet
    send_pkt(7, -1, -1, 0, stalls);
    #2 user_rstn = 1'b0;
    #1;
    expect_st("async_reset", 0, 0, 0, 0, S_IDLE);
    check_sb();
    chk("async_reset_tready", 64'(s_axis_tready), 64'd0);
    @(negedge user_clk);
    user_rstn = 1'b1;
    @(negedge user_clk);
    expect_st("post_reset_clean", 1, 0, 0, 0, S_RUN);
    send_pkt(2048, 2047, -1, 0, stalls);
    check_sb();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
